// File: rtl/eeg_pea_out_col.sv
// Output collector: round-robin serialisation of PE_ROW*PE_COL result streams
// into a single ORAM write port through a one-entry output register.
module eeg_pea_out_col #(
   parameter  int PE_ROW      = 4,
   parameter  int PE_COL      = 4,
   parameter  int DATA_OUT_DW = 8,
   parameter  int OMUX_ADD_AW = 8,
   parameter  int ORAM_ADD_AW = 10,
   localparam int NUM_CH      = PE_ROW * PE_COL,
   localparam int CH_AW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic                                                CFG_START,
   input  logic [ORAM_ADD_AW-1:0]                              CFG_BASE,
   output logic                                                IS_IDLE,
   output logic                                                DONE,
   input  logic [PE_COL-1:0][PE_ROW-1:0]                       OUT_VLD,
   input  logic [PE_COL-1:0][PE_ROW-1:0]                       OUT_LST,
   output logic [PE_COL-1:0][PE_ROW-1:0]                       OUT_RDY,
   input  logic [PE_COL-1:0][PE_ROW-1:0][DATA_OUT_DW-1:0]      OUT_DAT,
   input  logic [PE_COL-1:0][PE_ROW-1:0][OMUX_ADD_AW-1:0]      OUT_ADD,
   output logic                                                ORAM_WEN,
   input  logic                                                ORAM_RDY,
   output logic [CH_AW-1:0]                                    ORAM_BNK,
   output logic [ORAM_ADD_AW-1:0]                              ORAM_ADD,
   output logic [DATA_OUT_DW-1:0]                              ORAM_DAT
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t                  r_state;
   logic                    r_idle;
   logic                    r_done;
   logic [ORAM_ADD_AW-1:0]  r_base;
   logic [NUM_CH-1:0]       r_lst;
   logic [CH_AW-1:0]        r_rr;

   logic                    r_wen_p1;
   logic [CH_AW-1:0]        r_bnk_p1;
   logic [ORAM_ADD_AW-1:0]  r_add_p1;
   logic [DATA_OUT_DW-1:0]  r_dat_p1;

   // Flattened views: channel c = col*PE_ROW + row matches the packed bit order.
   logic [NUM_CH-1:0]                    w_vld;
   logic [NUM_CH-1:0]                    w_last;
   logic [NUM_CH-1:0][DATA_OUT_DW-1:0]   w_dat;
   logic [NUM_CH-1:0][OMUX_ADD_AW-1:0]   w_add;
   logic [NUM_CH-1:0]                    w_elig;
   logic [NUM_CH-1:0]                    w_rdy;
   logic                                 w_free;
   logic                                 w_drain;
   logic                                 w_gnt_vld;
   logic [CH_AW-1:0]                     w_gnt;
   logic [CH_AW-1:0]                     w_rr_nxt;
   logic [ORAM_ADD_AW-1:0]               w_add_sum;
   int                                   w_idx;

   assign w_vld   = OUT_VLD;
   assign w_last  = OUT_LST;
   assign w_dat   = OUT_DAT;
   assign w_add   = OUT_ADD;
   assign w_elig  = w_vld & ~r_lst & {NUM_CH{r_state == S_RUN}};
   assign w_free  = !r_wen_p1 || ORAM_RDY;
   assign w_drain = r_wen_p1 && ORAM_RDY;

   // Scan downward so the channel closest to r_rr is the last (winning) match.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_idx     = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         w_idx = (int'(r_rr) + i) % NUM_CH;
         if (w_elig[w_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = CH_AW'(w_idx);
         end
      end
      w_gnt_vld = w_gnt_vld && w_free;
   end

   always_comb begin
      w_rdy = '0;
      if (w_gnt_vld) w_rdy[w_gnt] = 1'b1;
   end

   assign w_rr_nxt  = CH_AW'((int'(w_gnt) + 1) % NUM_CH);
   assign w_add_sum = r_base + ORAM_ADD_AW'(w_add[w_gnt]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idle  <= 1'b1;
         r_done  <= 1'b0;
         r_base  <= '0;
         r_lst   <= '0;
         r_rr    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (CFG_START) begin
                  r_state <= S_RUN;
                  r_idle  <= 1'b0;
                  r_base  <= CFG_BASE;
                  r_lst   <= '0;
                  r_rr    <= '0;
               end
            end
            S_RUN: begin
               if (w_gnt_vld) begin
                  r_rr <= w_rr_nxt;
                  if (w_last[w_gnt]) r_lst[w_gnt] <= 1'b1;
               end
               if ((&r_lst) && w_free) begin
                  r_state <= S_FIN;
                  r_done  <= 1'b1;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_idle  <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_idle  <= 1'b1;
            end
         endcase
      end
   end

   // Output register stage: a grant overwrites a draining entry with no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wen_p1 <= 1'b0;
         r_bnk_p1 <= '0;
         r_add_p1 <= '0;
         r_dat_p1 <= '0;
      end else if (w_gnt_vld) begin
         r_wen_p1 <= 1'b1;
         r_bnk_p1 <= w_gnt;
         r_add_p1 <= w_add_sum;
         r_dat_p1 <= w_dat[w_gnt];
      end else if (w_drain) begin
         r_wen_p1 <= 1'b0;
      end
   end

   assign OUT_RDY  = w_rdy;
   assign IS_IDLE  = r_idle;
   assign DONE     = r_done;
   assign ORAM_WEN = r_wen_p1;
   assign ORAM_BNK = r_bnk_p1;
   assign ORAM_ADD = r_add_p1;
   assign ORAM_DAT = r_dat_p1;

endmodule

// File: tb/tb_eeg_pea_out_col.sv
// Directed bench for eeg_pea_out_col: single-PE run, round-robin streaming,
// ORAM back-pressure, address wrap, post-last valid, mid-run reset.
module tb_eeg_pea_out_col;

   logic              clk;
   logic              rst_n;
   logic              cfg_start;
   logic [9:0]        cfg_base;
   logic              is_idle;
   logic              done;
   logic [15:0]       vld;
   logic [15:0]       lst;
   logic [15:0]       rdy;
   logic [15:0][7:0]  dat;
   logic [15:0][7:0]  add;
   logic              oram_wen;
   logic              oram_rdy;
   logic [3:0]        oram_bnk;
   logic [9:0]        oram_add;
   logic [7:0]        oram_dat;

   int n_tot  = 0;
   int n_pass = 0;

   eeg_pea_out_col dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .CFG_START (cfg_start),
      .CFG_BASE  (cfg_base),
      .IS_IDLE   (is_idle),
      .DONE      (done),
      .OUT_VLD   (vld),
      .OUT_LST   (lst),
      .OUT_RDY   (rdy),
      .OUT_DAT   (dat),
      .OUT_ADD   (add),
      .ORAM_WEN  (oram_wen),
      .ORAM_RDY  (oram_rdy),
      .ORAM_BNK  (oram_bnk),
      .ORAM_ADD  (oram_add),
      .ORAM_DAT  (oram_dat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [9:0] base);
      cfg_base  = base;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   initial begin
      int g;
      rst_n = 1'b0; cfg_start = 1'b0; cfg_base = '0;
      vld = '0; lst = '0; dat = '0; add = '0; oram_rdy = 1'b1;
      tick(); tick();
      chk("rst_idle", is_idle, 1); chk("rst_done", done, 0);
      chk("rst_wen", oram_wen, 0); chk("rst_rdy", rdy, 0);
      chk("rst_add", oram_add, 0); chk("rst_bnk", oram_bnk, 0);
      rst_n = 1'b1;
      tick();

      // ---- Test 1: channel 5 sends three words, others only a last word ----
      start(10'h100);
      chk("t1_run_idle", is_idle, 0);
      vld = 16'h0020; add[5] = 8'd3; dat[5] = 8'hA1; lst = '0;
      #1 chk("t1_rdy_a", rdy, 16'h0020);
      tick();
      chk("t1_wen_a", oram_wen, 1); chk("t1_add_a", oram_add, 10'h103);
      chk("t1_bnk_a", oram_bnk, 5); chk("t1_dat_a", oram_dat, 8'hA1);
      add[5] = 8'd7; dat[5] = 8'hA2;
      tick();
      chk("t1_add_b", oram_add, 10'h107); chk("t1_dat_b", oram_dat, 8'hA2);
      add[5] = 8'd9; dat[5] = 8'hA3; lst[5] = 1'b1;
      tick();
      chk("t1_add_c", oram_add, 10'h109); chk("t1_bnk_c", oram_bnk, 5);
      vld = 16'hFFDF; lst = 16'hFFFF;
      for (int c = 0; c < 16; c++) begin add[c] = 8'(c); dat[c] = 8'(c); end
      for (int k = 0; k < 15; k++) begin
         g = (6 + k) % 16;
         #1 chk("t1_rr_rdy", rdy, 32'(16'h1 << g));
         tick();
         chk("t1_rr_bnk", oram_bnk, g); chk("t1_rr_add", oram_add, 10'h100 + g);
         chk("t1_no_done", done, 0);
         vld[g] = 1'b0;
      end
      tick();
      chk("t1_done", done, 1); chk("t1_fin_wen", oram_wen, 0); chk("t1_fin_idle", is_idle, 0);
      tick();
      chk("t1_done_pulse", done, 0); chk("t1_back_idle", is_idle, 1);

      // ---- Test 2: all channels valid, round robin, back-pressure ----
      start(10'h000);
      lst = '0; vld = 16'hFFFF;
      for (int c = 0; c < 16; c++) begin add[c] = 8'(2 * c); dat[c] = 8'(8'h10 + c); end
      for (int k = 0; k < 20; k++) begin
         #1 chk("t2_rdy", rdy, 32'(16'h1 << (k % 16)));
         tick();
         chk("t2_bnk", oram_bnk, k % 16); chk("t2_dat", oram_dat, 8'h10 + (k % 16));
         chk("t2_add", oram_add, 2 * (k % 16)); chk("t2_wen", oram_wen, 1);
      end
      oram_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1 chk("t2_stall_rdy", rdy, 0);
         tick();
         chk("t2_stall_wen", oram_wen, 1); chk("t2_stall_bnk", oram_bnk, 3);
         chk("t2_stall_dat", oram_dat, 8'h13); chk("t2_stall_add", oram_add, 6);
      end
      oram_rdy = 1'b1;
      #1 chk("t2_resume_rdy", rdy, 16'h0010);
      tick();
      chk("t2_resume_bnk", oram_bnk, 4); chk("t2_resume_dat", oram_dat, 8'h14);
      lst = 16'hFFFF;
      for (int k = 0; k < 16; k++) begin
         g = (5 + k) % 16;
         #1 chk("t2_lst_rdy", rdy, 32'(16'h1 << g));
         tick();
         chk("t2_lst_bnk", oram_bnk, g);
         vld[g] = 1'b0;
      end
      tick();
      chk("t2_done", done, 1);
      tick();
      chk("t2_idle", is_idle, 1);

      // ---- Test 3: address wrap, valid after last, start ignored in RUN ----
      start(10'h3F0);
      vld = 16'h0004; lst = 16'h0004; add[2] = 8'h20; dat[2] = 8'h55;
      tick();
      chk("t3_wrap_add", oram_add, 10'h010); chk("t3_wrap_bnk", oram_bnk, 2);
      chk("t3_wrap_dat", oram_dat, 8'h55);
      cfg_start = 1'b1; cfg_base = 10'h000;
      #1 chk("t3_post_lst_rdy", rdy, 0);
      tick();
      cfg_start = 1'b0;
      chk("t3_drained", oram_wen, 0); chk("t3_still_run", is_idle, 0);
      vld = 16'h0005; lst = 16'h0005; add[0] = 8'h01;
      #1 chk("t3_ch0_rdy", rdy, 16'h0001);
      tick();
      chk("t3_base_kept", oram_add, 10'h3F1);
      vld = 16'hFFFE; lst = 16'hFFFF;
      for (int c = 1; c < 16; c++) begin
         add[c] = 8'(c);
         if (c != 2) begin
            #1 chk("t3_rdy", rdy, 32'(16'h1 << c));
            tick();
            chk("t3_bnk", oram_bnk, c); chk("t3_add", oram_add, (10'h3F0 + c) & 10'h3FF);
            vld[c] = 1'b0;
         end
      end
      #1 chk("t3_ch2_never", rdy, 0);
      tick();
      chk("t3_done", done, 1);
      tick();
      chk("t3_idle", is_idle, 1);

      // ---- Test 4: asynchronous reset mid-run, then clean restart ----
      start(10'h000);
      vld = 16'hFFFF; lst = '0;
      for (int c = 0; c < 16; c++) add[c] = 8'(2 * c);
      tick(); tick(); tick();
      chk("t4_pre_wen", oram_wen, 1); chk("t4_pre_bnk", oram_bnk, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_rst_wen", oram_wen, 0); chk("t4_rst_bnk", oram_bnk, 0);
      chk("t4_rst_add", oram_add, 0); chk("t4_rst_dat", oram_dat, 0);
      chk("t4_rst_idle", is_idle, 1); chk("t4_rst_rdy", rdy, 0);
      tick();
      chk("t4_no_done", done, 0);
      rst_n = 1'b1;
      tick();
      start(10'h200);
      #1 chk("t4_new_rdy", rdy, 16'h0001);
      tick();
      chk("t4_new_bnk", oram_bnk, 0); chk("t4_new_add", oram_add, 10'h200);
      tick();
      chk("t4_next_bnk", oram_bnk, 1); chk("t4_next_add", oram_add, 10'h202);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
